// File: rtl/pgm_sched_pkg.sv
// pgm_pkg: register map, CTRL bit indices and sequencer state encoding.
package pgm_pkg;
  localparam logic [15:0] ADDR_CTRL = 16'h0000;
  localparam logic [15:0] ADDR_LEN = 16'h0001;
  localparam logic [15:0] ADDR_COUNT = 16'h0002;
  localparam logic [15:0] ADDR_GAP = 16'h0003;
  localparam logic [15:0] ADDR_STATUS = 16'h0004;
  localparam logic [15:0] ADDR_SENT = 16'h0005;
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP = 1;
  typedef enum logic [1:0] {IDLE, WAIT, READ, GAP} state_t;
endpackage

// File: rtl/pgm_sched_if.sv
// pgm_sched_if: localbus request/response between a config master and the scheduler.
interface pgm_sched_if;
  logic cfg2sched_cs;
  logic cfg2sched_rw;
  logic [15:0] cfg2sched_addr;
  logic [31:0] cfg2sched_wdata;
  logic sched2cfg_ack;
  logic [31:0] sched2cfg_rdata;
  modport master(output cfg2sched_cs, cfg2sched_rw, cfg2sched_addr, cfg2sched_wdata, input sched2cfg_ack, sched2cfg_rdata);
  modport slave(input cfg2sched_cs, cfg2sched_rw, cfg2sched_addr, cfg2sched_wdata, output sched2cfg_ack, sched2cfg_rdata);
endinterface

// File: rtl/pgm_sched_cfg.sv
// pgm_sched_cfg: localbus register file with one ack per cs assertion and START/STOP pulses.
module pgm_sched_cfg import pgm_pkg::*; (
  input logic clk,
  input logic rst_n,
  pgm_sched_if.slave bus,
  input logic busy,
  input logic [31:0] sent,
  output logic [7:0] len,
  output logic [31:0] count,
  output logic [15:0] gap,
  output logic start,
  output logic stop
);
  logic taken, acc, wr, ctrl_wr;
  logic [31:0] rd_val;
  always_comb begin
    acc = bus.cfg2sched_cs & ~taken;
    wr = acc & ~bus.cfg2sched_rw;
    ctrl_wr = wr & (bus.cfg2sched_addr == ADDR_CTRL);
    // STOP wins when both control bits are written together
    start = ctrl_wr & bus.cfg2sched_wdata[CTRL_START] & ~bus.cfg2sched_wdata[CTRL_STOP];
    stop = ctrl_wr & bus.cfg2sched_wdata[CTRL_STOP];
    rd_val = bus.cfg2sched_addr == ADDR_LEN ? {24'd0, len} :
             bus.cfg2sched_addr == ADDR_COUNT ? count :
             bus.cfg2sched_addr == ADDR_GAP ? {16'd0, gap} :
             bus.cfg2sched_addr == ADDR_STATUS ? {31'd0, busy} :
             bus.cfg2sched_addr == ADDR_SENT ? sent : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      taken <= 1'b0;
      bus.sched2cfg_ack <= 1'b0;
      bus.sched2cfg_rdata <= '0;
      len <= '0;
      count <= '0;
      gap <= '0;
    end else begin
      taken <= bus.cfg2sched_cs;
      bus.sched2cfg_ack <= acc;
      bus.sched2cfg_rdata <= (acc & bus.cfg2sched_rw) ? rd_val : '0;
      if (wr & (bus.cfg2sched_addr == ADDR_LEN)) len <= bus.cfg2sched_wdata[7:0];
      if (wr & (bus.cfg2sched_addr == ADDR_COUNT)) count <= bus.cfg2sched_wdata;
      if (wr & (bus.cfg2sched_addr == ADDR_GAP)) gap <= bus.cfg2sched_wdata[15:0];
    end
endmodule

// File: rtl/pgm_sched.sv
// pgm_sched: localbus-programmed packet generator replaying packet-RAM words as bursts.
module pgm_sched import pgm_pkg::*; #(
  parameter PLATFORM = "Xilinx",
  parameter int PKT_MAX_WORDS = 128
) (
  input logic clk,
  input logic rst_n,
  pgm_sched_if.slave cfg,
  output logic sched2ram_rd,
  output logic [6:0] sched2ram_raddr,
  input logic [143:0] ram2sched_rdata,
  output logic [133:0] out_sched_data,
  output logic out_sched_data_wr,
  output logic out_sched_valid_wr,
  output logic out_sched_valid,
  input logic in_sched_alf,
  output logic sched_busy
);
  state_t state, ns, end_ns;
  logic [7:0] len, len_s, cnt;
  logic [31:0] count, count_s, sent;
  logic [15:0] gap, gap_s, gcnt;
  logic start, stop, stop_pend, stop_any, start_ok, issue, last, rd_d, last_d, unused_ok;
  pgm_sched_cfg u_cfg (
    .clk(clk), .rst_n(rst_n), .bus(cfg), .busy(sched_busy), .sent(sent),
    .len(len), .count(count), .gap(gap), .start(start), .stop(stop)
  );
  // WAIT issues word 0 itself when alf is clear, so GAP=0 bursts run back to back
  always_comb begin
    stop_any = stop_pend | stop;
    start_ok = start & (len != 8'd0) & (32'(len) <= PKT_MAX_WORDS) & (count != 32'd0);
    issue = (state == READ) | ((state == WAIT) & ~in_sched_alf & ~stop_any);
    last = issue & (cnt == len_s - 8'd1);
    end_ns = ((sent + 32'd1 == count_s) | stop_any) ? IDLE : gap_s == 16'd0 ? WAIT : GAP;
    ns = state;
    case (state)
      IDLE: ns = start_ok ? WAIT : IDLE;
      WAIT: ns = stop_any ? IDLE : !issue ? WAIT : last ? end_ns : READ;
      READ: ns = last ? end_ns : READ;
      GAP: ns = stop_any ? IDLE : gcnt == gap_s - 16'd1 ? WAIT : GAP;
      default: ns = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      gcnt <= '0;
      sent <= '0;
      len_s <= '0;
      count_s <= '0;
      gap_s <= '0;
      stop_pend <= 1'b0;
      rd_d <= 1'b0;
      last_d <= 1'b0;
    end else begin
      state <= ns;
      rd_d <= issue;
      last_d <= last;
      stop_pend <= ns == IDLE ? 1'b0 : stop_pend | (stop & state != IDLE);
      gcnt <= state == GAP ? gcnt + 16'd1 : '0;
      if (issue) cnt <= last ? '0 : cnt + 8'd1;
      if (start_ok & state == IDLE) begin
        len_s <= len;
        count_s <= count;
        gap_s <= gap;
        sent <= '0;
      end
      if (last) sent <= sent + 32'd1;
    end
  assign sched2ram_rd = issue;
  assign sched2ram_raddr = issue ? cnt[6:0] : '0;
  assign out_sched_data = rd_d ? ram2sched_rdata[133:0] : '0;
  assign out_sched_data_wr = rd_d;
  assign out_sched_valid_wr = last_d;
  assign out_sched_valid = last_d;
  assign sched_busy = state != IDLE;
  assign unused_ok = ^{ram2sched_rdata[143:134], cnt[7], PLATFORM == "Xilinx"};
endmodule
